// File: rtl/instr_sequencer_if.sv
// Opcode set shared with the control decoder, plus the ROM/decoder-facing bundle of the
// instruction sequencer (master = sequencer, slave = ROM and decoder side).
package opcodes;
   typedef enum logic [3:0] {
      NOOP  = 4'h0,
      ADD   = 4'h1,
      SUB   = 4'h2,
      MULT  = 4'h3,
      PASSA = 4'h4,
      PASSB = 4'h5,
      LOADA = 4'h6,
      STACC = 4'h7,
      WAIT  = 4'h8
   } opcodes_t;
endpackage

interface instr_sequencer_if #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 16
);
   localparam int OP_WIDTH = $bits(opcodes::opcodes_t);

   logic [PC_WIDTH-1:0]             ProgAddr;
   logic [INSTR_WIDTH-1:0]          ProgData;
   logic                            PcWait;
   logic                            Cond;
   opcodes::opcodes_t               OpCode;
   logic [INSTR_WIDTH-OP_WIDTH-1:0] Operand;
   logic [PC_WIDTH-1:0]             Pc;
   logic                            Issue;

   modport master (
      output ProgAddr, OpCode, Operand, Pc, Issue,
      input  ProgData, PcWait, Cond
   );

   modport slave (
      input  ProgAddr, OpCode, Operand, Pc, Issue,
      output ProgData, PcWait, Cond
   );
endinterface

// File: rtl/instr_sequencer.sv
// Program counter and FETCH/LOAD/ISSUE sequencer feeding the control decoder from a synchronous ROM.
// Optional single-step gating is enabled by defining SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 16
) (
   input  logic Clock,
   input  logic Reset,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic Step,
   input  logic StepMode,
`endif
   instr_sequencer_if.master bus
);
   localparam int OP_WIDTH = $bits(opcodes::opcodes_t);

   typedef enum logic [1:0] {FETCH, LOAD, ISSUE} seqState_t;

   seqState_t              state;
   logic [PC_WIDTH-1:0]    pcReg;
   logic [INSTR_WIDTH-1:0] ir;
   logic                   issueReg;
   opcodes::opcodes_t      irOp;
   logic                   stepGate;
   logic                   advance;

   assign irOp = opcodes::opcodes_t'(ir[INSTR_WIDTH-1 -: OP_WIDTH]);

`ifdef SEQ_SINGLE_STEP_EN
   logic stepPrev;

   // Rising-edge detector so a held Step button releases only one instruction
   always_ff @(posedge Clock) begin
      if (Reset) stepPrev <= 1'b0;
      else       stepPrev <= Step;
   end

   assign stepGate = !StepMode || (Step && !stepPrev);
`else
   assign stepGate = 1'b1;
`endif

   assign advance = !bus.PcWait && ((irOp != opcodes::WAIT) || bus.Cond) && stepGate;

   // IR is cleared when an instruction retires, so NOOP/zero operand appear outside ISSUE for free
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= FETCH;
         pcReg    <= '0;
         ir       <= '0;
         issueReg <= 1'b0;
      end else begin
         case (state)
            FETCH: state <= LOAD;
            LOAD: begin
               ir       <= bus.ProgData;
               issueReg <= 1'b1;
               state    <= ISSUE;
            end
            ISSUE: begin
               if (advance) begin
                  pcReg    <= pcReg + PC_WIDTH'(1);
                  ir       <= '0;
                  issueReg <= 1'b0;
                  state    <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   assign bus.ProgAddr = pcReg;
   assign bus.Pc       = pcReg;
   assign bus.OpCode   = irOp;
   assign bus.Operand  = ir[INSTR_WIDTH-OP_WIDTH-1:0];
   assign bus.Issue    = issueReg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a synchronous ROM model, a scoreboard of expected issues
// popped on each new Issue, and cycle-accurate checks of timing, stalls, WAIT and PC wrap.
module tb_instr_sequencer;
   localparam int PC_WIDTH    = 8;
   localparam int INSTR_WIDTH = 16;

   typedef struct packed {
      logic [3:0]  op;
      logic [11:0] operand;
      logic [7:0]  pc;
   } sbEntry_t;

   logic Clock = 1'b0;
   logic Reset;
   int   vectors     = 0;
   int   miscompares = 0;
   logic issuePrev   = 1'b0;

   logic [INSTR_WIDTH-1:0] rom [256];
   sbEntry_t               sbQ [$];

`ifdef SEQ_SINGLE_STEP_EN
   logic Step;
   logic StepMode;
`endif

   instr_sequencer_if #(.PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) bus ();
   instr_sequencer_if #(.PC_WIDTH(2), .INSTR_WIDTH(INSTR_WIDTH)) bus2 ();

   instr_sequencer #(.PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
`ifdef SEQ_SINGLE_STEP_EN
      .Step     (Step),
      .StepMode (StepMode),
`endif
      .bus      (bus.master)
   );

   // Narrow instance running a ROM of NOOPs to exercise PC wrap-around
   instr_sequencer #(.PC_WIDTH(2), .INSTR_WIDTH(INSTR_WIDTH)) dutWrap (
      .Clock    (Clock),
      .Reset    (Reset),
`ifdef SEQ_SINGLE_STEP_EN
      .Step     (1'b0),
      .StepMode (1'b0),
`endif
      .bus      (bus2.master)
   );

   assign bus2.ProgData = '0;
   assign bus2.PcWait   = 1'b0;
   assign bus2.Cond     = 1'b0;

   always #5 Clock = ~Clock;

   always @(posedge Clock) bus.ProgData <= rom[bus.ProgAddr];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Every new issue must match the oldest outstanding expectation
   always @(negedge Clock) begin
      sbEntry_t e;
      if (bus.Issue === 1'b1 && !issuePrev) begin
         checkOutput("sbOccupancy", 32'(sbQ.size() > 0), 32'd1);
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("issueOp", bus.OpCode, e.op);
            checkOutput("issueOperand", bus.Operand, e.operand);
            checkOutput("issuePc", bus.Pc, e.pc);
         end
      end
      issuePrev = (bus.Issue === 1'b1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic applyStimulus(input logic pcWaitV, input logic condV, input int n);
      bus.PcWait = pcWaitV;
      bus.Cond   = condV;
      tick(n);
   endtask

   task automatic resetDut();
      @(negedge Clock);
      Reset      = 1'b1;
      bus.PcWait = 1'b0;
      bus.Cond   = 1'b0;
      @(negedge Clock);
      Reset      = 1'b0;
   endtask

   task automatic clearRom();
      for (int i = 0; i < 256; i++) rom[i] = {opcodes::WAIT, 12'h000};
   endtask

   task automatic expectIssue(input logic [3:0] op, input logic [11:0] operand, input logic [7:0] pc);
      sbQ.push_back('{op: op, operand: operand, pc: pc});
   endtask

   task automatic endTest();
      tick(4);
      checkOutput("sbDrained", sbQ.size(), 0);
   endtask

   initial begin
      Reset      = 1'b1;
      bus.PcWait = 1'b0;
      bus.Cond   = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      Step       = 1'b0;
      StepMode   = 1'b0;
`endif
      clearRom();

      // Reset values, then the narrow instance wraps after four NOOPs
      expectIssue(opcodes::WAIT, 12'h000, 8'd0);
      resetDut();
      checkOutput("rstProgAddr", bus.ProgAddr, 0);
      checkOutput("rstPc", bus.Pc, 0);
      checkOutput("rstOpCode", bus.OpCode, opcodes::NOOP);
      checkOutput("rstOperand", bus.Operand, 0);
      checkOutput("rstIssue", bus.Issue, 0);
      checkOutput("wrapPcStart", bus2.Pc, 0);
      tick(9);
      checkOutput("wrapPcAt10", bus2.Pc, 3);
      tick(3);
      checkOutput("wrapProgAddr", bus2.ProgAddr, 0);
      checkOutput("wrapPc", bus2.Pc, 0);
      endTest();

      // Single ADD: fetch at cycle 1, issue at cycle 3, next fetch at cycle 4
      clearRom();
      rom[0] = {opcodes::ADD, 12'h005};
      expectIssue(opcodes::ADD, 12'h005, 8'd0);
      expectIssue(opcodes::WAIT, 12'h000, 8'd1);
      resetDut();
      checkOutput("addProgAddr1", bus.ProgAddr, 0);
      tick(2);
      checkOutput("addOpCode3", bus.OpCode, opcodes::ADD);
      checkOutput("addOperand3", bus.Operand, 12'h005);
      checkOutput("addIssue3", bus.Issue, 1);
      tick(1);
      checkOutput("addProgAddr4", bus.ProgAddr, 1);
      checkOutput("addOpCode4", bus.OpCode, opcodes::NOOP);
      checkOutput("addIssue4", bus.Issue, 0);
      endTest();

      // Three back-to-back instructions at the base rate
      clearRom();
      rom[0] = {opcodes::PASSA, 12'h011};
      rom[1] = {opcodes::ADD,   12'h022};
      rom[2] = {opcodes::STACC, 12'h033};
      expectIssue(opcodes::PASSA, 12'h011, 8'd0);
      expectIssue(opcodes::ADD,   12'h022, 8'd1);
      expectIssue(opcodes::STACC, 12'h033, 8'd2);
      expectIssue(opcodes::WAIT,  12'h000, 8'd3);
      resetDut();
      for (int c = 1; c <= 10; c++) begin
         checkOutput("rateIssue", bus.Issue, 32'(c == 3 || c == 6 || c == 9));
         if (c == 10) checkOutput("ratePc10", bus.Pc, 3);
         else tick(1);
      end
      endTest();

      // WAIT held for ten issue cycles, released by Cond
      clearRom();
      expectIssue(opcodes::WAIT, 12'h000, 8'd0);
      expectIssue(opcodes::WAIT, 12'h000, 8'd1);
      resetDut();
      tick(2);
      for (int i = 0; i < 10; i++) begin
         checkOutput("waitHoldOp", bus.OpCode, opcodes::WAIT);
         checkOutput("waitHoldIssue", bus.Issue, 1);
         if (i == 9) bus.Cond = 1'b1;
         tick(1);
      end
      checkOutput("waitReleasePc", bus.Pc, 1);
      checkOutput("waitReleaseIssue", bus.Issue, 0);
      bus.Cond = 1'b0;
      endTest();

      // PcWait for four cycles stretches MULT to five issue cycles
      clearRom();
      rom[0] = {opcodes::MULT, 12'h0AB};
      expectIssue(opcodes::MULT, 12'h0AB, 8'd0);
      expectIssue(opcodes::WAIT, 12'h000, 8'd1);
      resetDut();
      tick(2);
      for (int i = 0; i < 5; i++) begin
         bus.PcWait = (i < 4);
         checkOutput("stallOp", bus.OpCode, opcodes::MULT);
         checkOutput("stallOperand", bus.Operand, 12'h0AB);
         checkOutput("stallPc", bus.Pc, 0);
         tick(1);
      end
      checkOutput("stallPcAfter", bus.Pc, 1);
      checkOutput("stallOpAfter", bus.OpCode, opcodes::NOOP);
      endTest();

      // PcWait during FETCH and LOAD has no effect
      clearRom();
      rom[0] = {opcodes::SUB, 12'h001};
      expectIssue(opcodes::SUB,  12'h001, 8'd0);
      expectIssue(opcodes::WAIT, 12'h000, 8'd1);
      resetDut();
      applyStimulus(1'b1, 1'b0, 2);
      bus.PcWait = 1'b0;
      checkOutput("earlyWaitIssue", bus.Issue, 1);
      checkOutput("earlyWaitOp", bus.OpCode, opcodes::SUB);
      tick(1);
      checkOutput("earlyWaitPc", bus.Pc, 1);
      endTest();

      // PcWait and WAIT pending together must both clear
      clearRom();
      expectIssue(opcodes::WAIT, 12'h000, 8'd0);
      expectIssue(opcodes::WAIT, 12'h000, 8'd1);
      resetDut();
      tick(2);
      applyStimulus(1'b1, 1'b1, 0);
      checkOutput("bothPc", bus.Pc, 0);
      applyStimulus(1'b1, 1'b1, 1);
      checkOutput("bothIssueA", bus.Issue, 1);
      applyStimulus(1'b1, 1'b0, 1);
      checkOutput("bothIssueB", bus.Issue, 1);
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("bothIssueC", bus.Issue, 1);
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("bothPcAfter", bus.Pc, 1);
      bus.Cond = 1'b0;
      endTest();

      // WAIT with Cond already high advances on its first issue cycle
      clearRom();
      expectIssue(opcodes::WAIT, 12'h000, 8'd0);
      expectIssue(opcodes::WAIT, 12'h000, 8'd1);
      resetDut();
      bus.Cond = 1'b1;
      tick(2);
      checkOutput("levelIssue", bus.Issue, 1);
      tick(1);
      checkOutput("levelPc", bus.Pc, 1);
      bus.Cond = 1'b0;
      endTest();

      // Unknown encoding passes through unchanged
      clearRom();
      rom[0] = 16'hC123;
      expectIssue(4'hC, 12'h123, 8'd0);
      expectIssue(opcodes::WAIT, 12'h000, 8'd1);
      resetDut();
      tick(2);
      checkOutput("unknownOp", bus.OpCode, 4'hC);
      endTest();

      // Reset in the middle of a WAIT stall restarts cleanly
      clearRom();
      expectIssue(opcodes::WAIT, 12'h000, 8'd0);
      expectIssue(opcodes::WAIT, 12'h000, 8'd0);
      resetDut();
      tick(5);
      checkOutput("midWaitIssue", bus.Issue, 1);
      resetDut();
      checkOutput("midRstIssue", bus.Issue, 0);
      checkOutput("midRstPc", bus.Pc, 0);
      checkOutput("midRstProgAddr", bus.ProgAddr, 0);
      checkOutput("midRstOp", bus.OpCode, opcodes::NOOP);
      endTest();

`ifdef SEQ_SINGLE_STEP_EN
      // Two Step pulses release exactly two instructions
      clearRom();
      rom[0] = {opcodes::ADD,  12'h001};
      rom[1] = {opcodes::SUB,  12'h002};
      rom[2] = {opcodes::MULT, 12'h003};
      expectIssue(opcodes::ADD,  12'h001, 8'd0);
      expectIssue(opcodes::SUB,  12'h002, 8'd1);
      expectIssue(opcodes::MULT, 12'h003, 8'd2);
      StepMode = 1'b1;
      resetDut();
      tick(4);
      Step = 1'b1;
      tick(1);
      Step = 1'b0;
      checkOutput("stepPc1", bus.Pc, 1);
      tick(4);
      Step = 1'b1;
      tick(1);
      Step = 1'b0;
      checkOutput("stepPc2", bus.Pc, 2);
      tick(9);
      checkOutput("stepHoldPc", bus.Pc, 2);
      checkOutput("stepHoldOp", bus.OpCode, opcodes::MULT);
      checkOutput("stepHoldIssue", bus.Issue, 1);
      checkOutput("stepDrained", sbQ.size(), 0);
      StepMode = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] simulation did not complete");
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction-issue end of the control path. Owns the program counter and fetches instruction words from a synchronous program ROM.
- Latches each fetched word into an instruction register and presents its OpCode to the control decoder for exactly one issue window.
- Honours the decoder's PcWait stall and the WAIT opcode (holds until Cond), then advances the PC.
- Sits between the program ROM and the control decoder.

Parameters:
- PC_WIDTH, 8: program counter and ROM address width; ROM depth 2**PC_WIDTH.
- INSTR_WIDTH, 16: instruction word width. OpCode is the top bits, width of opcodes::opcodes_t. Operand is the remaining low bits.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- ProgAddr  out  PC_WIDTH  ROM read address; ROM data valid one cycle later.
- ProgData  in  INSTR_WIDTH  ROM read data.
- PcWait  in  1  stall request from the control decoder; holds the current issue.
- Cond  in  1  external condition/button; releases a WAIT.
- OpCode  out  opcodes::opcodes_t  opcode to the control decoder; NOOP outside ISSUE.
- Operand  out  INSTR_WIDTH-opcode width  low instruction field for the datapath.
- Pc  out  PC_WIDTH  current program counter, for debug/LEDs.
- Issue  out  1  high while OpCode holds a live instruction.

Behaviour:
Reset (Reset high at a rising edge):
- PC=0, IR=0, state=FETCH.
- Outputs: ProgAddr=0, OpCode=NOOP, Operand=0, Issue=0, Pc=0.
- Reset overrides everything, including a stall or WAIT mid-instruction; no partial instruction survives.

FSM, three states:
- FETCH: ProgAddr=PC; go to LOAD.
- LOAD: IR<=ProgData; go to ISSUE.
- ISSUE: OpCode=IR opcode field, Operand=IR low field, Issue=1.
  - Advance condition: PcWait==0, and (OpCode!=WAIT or Cond==1).
  - On advance: PC<=PC+1, go to FETCH.
  - Otherwise stay in ISSUE with OpCode/Operand stable.

Timing and outputs:
- Base rate: 3 cycles per instruction; each cycle spent stalled in ISSUE adds one cycle.
- In FETCH and LOAD: OpCode=NOOP, Operand=0, Issue=0, so the decoder asserts no write enables.
- ProgAddr is driven from PC in every state; only FETCH relies on it.

Boundary conditions:
- PC wraps from 2**PC_WIDTH-1 to 0; no flag.
- WAIT with Cond already high on the first ISSUE cycle advances immediately (a level test, not an edge).
- PcWait and WAIT pending together: both must clear before advancing.
- PcWait seen in FETCH or LOAD is ignored.
- Unknown opcode encodings are issued unchanged; the decoder defaults them to no-ops.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input Step (1 bit) and input StepMode (1 bit).
  - With StepMode=1, the ISSUE advance condition additionally requires Step==1, sampled on a rising edge where Step was 0 the previous cycle. Exactly one instruction per Step pulse.
  - With StepMode=0, behaviour is identical to the undefined build.
  - The Step edge detector resets to 0.
- Undefined: ports Step and StepMode are absent; no stepping logic.

Test Plan:
- Reset, ROM[0]={ADD,0x05}, PcWait=0: cycle 1 ProgAddr=0, cycle 3 OpCode=ADD, Operand=0x05, Issue=1; cycle 4 ProgAddr=1, OpCode=NOOP.
- ROM[0..2]={PASSA,ADD,STACC}, no stalls: each OpCode issued for exactly one cycle at cycles 3, 6, 9; Pc reads 3 at cycle 10.
- ROM[0]=WAIT, Cond=0 for 10 cycles then 1: OpCode=WAIT held for 10 issue cycles; advances on the first Cond=1 edge; Pc=1.
- PcWait=1 for 4 cycles during ISSUE of MULT: OpCode=MULT stable for 5 cycles total; PC increments once.
- PC_WIDTH=2, ROM of 4 NOOPs: after 4 instructions ProgAddr returns to 0.
- Reset asserted during a WAIT stall: next cycle state=FETCH, Pc=0, Issue=0. SEQ_SINGLE_STEP_EN build with StepMode=1 and two Step pulses: exactly 2 instructions issued.
